// File: rtl/parking_gate_controller_if.sv
// ---------------------------------------------------------------------------
// parking_gate_controller_if
//
// Bundles the barrier sensors, occupancy flags and controller outputs of the
// parking gate controller into one connection.
//
//   Parameter CNT_W : width of the statistics counters.
//
//   Driven by the environment (master -> slave):
//     entry_request, entry_is_uni, entry_passed   entry barrier request/class/loop
//     exit_request,  exit_is_uni,  exit_passed    exit barrier request/class/loop
//     uni_is_vacated_space, free_is_vacated_space occupancy counter space flags
//
//   Driven by the controller (slave -> master):
//     car_entered, is_uni_car_entered             completed entry pulse + class
//     car_exited,  is_uni_car_exited              completed exit pulse + class
//     entry_gate_open, exit_gate_open             barrier drives
//     entry_denied                                entry refused (no space) pulse
//     gate_timeout[1:0]                           bit0 entry, bit1 exit timeout
//     entry_count, exit_count, denied_count       saturating statistics
// ---------------------------------------------------------------------------
interface parking_gate_controller_if #(
    parameter int CNT_W = 10
) ();

    logic             entry_request;
    logic             entry_is_uni;
    logic             entry_passed;
    logic             exit_request;
    logic             exit_is_uni;
    logic             exit_passed;
    logic             uni_is_vacated_space;
    logic             free_is_vacated_space;

    logic             car_entered;
    logic             is_uni_car_entered;
    logic             car_exited;
    logic             is_uni_car_exited;
    logic             entry_gate_open;
    logic             exit_gate_open;
    logic             entry_denied;
    logic [1:0]       gate_timeout;
    logic [CNT_W-1:0] entry_count;
    logic [CNT_W-1:0] exit_count;
    logic [CNT_W-1:0] denied_count;

    // Environment side: drives sensors and flags, observes the controller.
    modport master (
        output entry_request, entry_is_uni, entry_passed,
        output exit_request, exit_is_uni, exit_passed,
        output uni_is_vacated_space, free_is_vacated_space,
        input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
        input  entry_gate_open, exit_gate_open, entry_denied, gate_timeout,
        input  entry_count, exit_count, denied_count
    );

    // Controller side.
    modport slave (
        input  entry_request, entry_is_uni, entry_passed,
        input  exit_request, exit_is_uni, exit_passed,
        input  uni_is_vacated_space, free_is_vacated_space,
        output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
        output entry_gate_open, exit_gate_open, entry_denied, gate_timeout,
        output entry_count, exit_count, denied_count
    );

endinterface

// File: rtl/parking_gate_controller.sv
// ---------------------------------------------------------------------------
// parking_gate_controller
//
// Two independent barrier FSMs (entry and exit), each IDLE -> OPEN -> REPORT
// -> HOLD -> IDLE. Entry checks the space flag matching the car class before
// opening; exit always opens. An open gate closes either when the loop sensor
// reports the car through (-> REPORT, one car pulse) or after GATE_TIMEOUT
// cycles (-> IDLE, one timeout pulse). HOLD keeps the reported class stable
// for one cycle after the car pulse so the downstream counter, which counts
// on the falling edge of the pulse, samples a settled class.
//
// Ports:
//   clock   : system clock, all state changes on its rising edge
//   reset   : synchronous active-high reset
//   bus     : parking_gate_controller_if.slave (sensors, flags, outputs)
//
// Parameters:
//   GATE_TIMEOUT : max cycles a barrier stays open (2..255), default 16
//   CNT_W        : statistics counter width, default 10
// ---------------------------------------------------------------------------
module parking_gate_controller #(
    parameter int GATE_TIMEOUT = 16,
    parameter int CNT_W        = 10
) (
    input  logic                            clock,
    input  logic                            reset,
    parking_gate_controller_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE,
        OPEN,
        REPORT,
        HOLD
    } lane_state_t;

    // Wait counter runs 0..GATE_TIMEOUT-1; the last value triggers timeout.
    localparam logic [7:0] WAIT_LAST = 8'(GATE_TIMEOUT - 1);

    // Counters stop at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + CNT_W'(1);
    endfunction

    // ---------------------------------------------------------------- entry
    lane_state_t      entry_state_q;
    logic             entry_class_q;
    logic [7:0]       entry_wait_q;
    logic             entry_gate_q;
    logic             car_entered_q;
    logic             is_uni_entered_q;
    logic             entry_denied_q;
    logic             entry_timeout_q;
    logic [CNT_W-1:0] entry_count_q;
    logic [CNT_W-1:0] denied_count_q;
    logic             entry_space;

    // Space is judged against the class presented with this request.
    assign entry_space = bus.entry_is_uni ? bus.uni_is_vacated_space
                                          : bus.free_is_vacated_space;

    always_ff @(posedge clock) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // samples pre-edge values; reset is synchronous and clears the
        // statistics counters as well as the FSM.
        if (reset) begin
            entry_state_q    <= IDLE;
            entry_class_q    <= 1'b0;
            entry_wait_q     <= '0;
            entry_gate_q     <= 1'b0;
            car_entered_q    <= 1'b0;
            is_uni_entered_q <= 1'b0;
            entry_denied_q   <= 1'b0;
            entry_timeout_q  <= 1'b0;
            entry_count_q    <= '0;
            denied_count_q   <= '0;
        end else begin
            // Pulse outputs default low; the branches below raise them for
            // exactly one cycle.
            car_entered_q   <= 1'b0;
            entry_denied_q  <= 1'b0;
            entry_timeout_q <= 1'b0;

            case (entry_state_q)
                IDLE: begin
                    if (bus.entry_request) begin
                        entry_class_q <= bus.entry_is_uni;
                        if (entry_space) begin
                            entry_state_q <= OPEN;
                            entry_gate_q  <= 1'b1;
                            entry_wait_q  <= '0;
                        end else begin
                            entry_denied_q <= 1'b1;
                            denied_count_q <= sat_inc(denied_count_q);
                        end
                    end
                end
                OPEN: begin
                    // A car passing on the last allowed cycle still counts.
                    if (bus.entry_passed) begin
                        entry_state_q    <= REPORT;
                        entry_gate_q     <= 1'b0;
                        car_entered_q    <= 1'b1;
                        is_uni_entered_q <= entry_class_q;
                        entry_count_q    <= sat_inc(entry_count_q);
                    end else if (entry_wait_q == WAIT_LAST) begin
                        entry_state_q   <= IDLE;
                        entry_gate_q    <= 1'b0;
                        entry_timeout_q <= 1'b1;
                    end else begin
                        entry_wait_q <= entry_wait_q + 8'd1;
                    end
                end
                REPORT:  entry_state_q <= HOLD;
                HOLD:    entry_state_q <= IDLE;
                default: entry_state_q <= IDLE;
            endcase
        end
    end

    // ----------------------------------------------------------------- exit
    lane_state_t      exit_state_q;
    logic             exit_class_q;
    logic [7:0]       exit_wait_q;
    logic             exit_gate_q;
    logic             car_exited_q;
    logic             is_uni_exited_q;
    logic             exit_timeout_q;
    logic [CNT_W-1:0] exit_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            exit_state_q    <= IDLE;
            exit_class_q    <= 1'b0;
            exit_wait_q     <= '0;
            exit_gate_q     <= 1'b0;
            car_exited_q    <= 1'b0;
            is_uni_exited_q <= 1'b0;
            exit_timeout_q  <= 1'b0;
            exit_count_q    <= '0;
        end else begin
            car_exited_q   <= 1'b0;
            exit_timeout_q <= 1'b0;

            case (exit_state_q)
                IDLE: begin
                    // Leaving never needs a space check.
                    if (bus.exit_request) begin
                        exit_class_q <= bus.exit_is_uni;
                        exit_state_q <= OPEN;
                        exit_gate_q  <= 1'b1;
                        exit_wait_q  <= '0;
                    end
                end
                OPEN: begin
                    if (bus.exit_passed) begin
                        exit_state_q    <= REPORT;
                        exit_gate_q     <= 1'b0;
                        car_exited_q    <= 1'b1;
                        is_uni_exited_q <= exit_class_q;
                        exit_count_q    <= sat_inc(exit_count_q);
                    end else if (exit_wait_q == WAIT_LAST) begin
                        exit_state_q   <= IDLE;
                        exit_gate_q    <= 1'b0;
                        exit_timeout_q <= 1'b1;
                    end else begin
                        exit_wait_q <= exit_wait_q + 8'd1;
                    end
                end
                REPORT:  exit_state_q <= HOLD;
                HOLD:    exit_state_q <= IDLE;
                default: exit_state_q <= IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------- outputs
    assign bus.car_entered        = car_entered_q;
    assign bus.is_uni_car_entered = is_uni_entered_q;
    assign bus.car_exited         = car_exited_q;
    assign bus.is_uni_car_exited  = is_uni_exited_q;
    assign bus.entry_gate_open    = entry_gate_q;
    assign bus.exit_gate_open     = exit_gate_q;
    assign bus.entry_denied       = entry_denied_q;
    assign bus.gate_timeout       = {exit_timeout_q, entry_timeout_q};
    assign bus.entry_count        = entry_count_q;
    assign bus.exit_count         = exit_count_q;
    assign bus.denied_count       = denied_count_q;

endmodule

// File: tb/tb_parking_gate_controller.sv
// ---------------------------------------------------------------------------
// tb_parking_gate_controller
//
// Scoreboard bench: each scenario task pushes the pulse events it expects
// (car with class, denied, timeout) onto a per-lane queue when it drives the
// request; a negedge monitor pops and compares whenever the DUT emits one.
// Tasks also compare gate-open durations, pulse latency, held class and the
// statistics counters against a small reference model kept in the bench.
// ---------------------------------------------------------------------------
module tb_parking_gate_controller;

    localparam int GATE_TIMEOUT = 16;
    localparam int CNT_W        = 10;
    localparam int SAT          = (1 << CNT_W) - 1;

    // Event encoding: {car, car&class, denied, timeout}
    localparam logic [3:0] EV_CAR_UNI  = 4'b1100;
    localparam logic [3:0] EV_CAR_FREE = 4'b1000;
    localparam logic [3:0] EV_DENIED   = 4'b0010;
    localparam logic [3:0] EV_TIMEOUT  = 4'b0001;

    logic clock = 1'b0;
    logic reset = 1'b1;

    parking_gate_controller_if #(.CNT_W(CNT_W)) bus ();

    parking_gate_controller #(
        .GATE_TIMEOUT(GATE_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    logic [3:0] en_q[$];
    logic [3:0] ex_q[$];

    int   exp_en_cnt = 0;
    int   exp_ex_cnt = 0;
    int   exp_dn_cnt = 0;
    logic exp_en_uni = 1'b0;
    logic exp_ex_uni = 1'b0;

    logic [3:0] en_obs, ex_obs, en_exp, ex_exp;

    // ------------------------------------------------------------ monitor
    always @(negedge clock) begin
        if (!reset) begin
            en_obs = {bus.car_entered, bus.car_entered & bus.is_uni_car_entered,
                      bus.entry_denied, bus.gate_timeout[0]};
            ex_obs = {bus.car_exited, bus.car_exited & bus.is_uni_car_exited,
                      1'b0, bus.gate_timeout[1]};
            if (en_obs !== 4'b0000) begin
                total++;
                if (en_q.size() == 0) begin
                    bad++;
                    $display("FAIL entry_event: got %b, expected no event", en_obs);
                end else begin
                    en_exp = en_q.pop_front();
                    if (en_obs !== en_exp) begin
                        bad++;
                        $display("FAIL entry_event: got %b, expected %b", en_obs, en_exp);
                    end
                end
            end
            if (ex_obs !== 4'b0000) begin
                total++;
                if (ex_q.size() == 0) begin
                    bad++;
                    $display("FAIL exit_event: got %b, expected no event", ex_obs);
                end else begin
                    ex_exp = ex_q.pop_front();
                    if (ex_obs !== ex_exp) begin
                        bad++;
                        $display("FAIL exit_event: got %b, expected %b", ex_obs, ex_exp);
                    end
                end
            end
        end
    end

    task automatic drive_idle();
        bus.entry_request         = 1'b0;
        bus.entry_is_uni          = 1'b0;
        bus.entry_passed          = 1'b0;
        bus.exit_request          = 1'b0;
        bus.exit_is_uni           = 1'b0;
        bus.exit_passed           = 1'b0;
        bus.uni_is_vacated_space  = 1'b0;
        bus.free_is_vacated_space = 1'b0;
    endtask

    task automatic check_counts(input string tag);
        total++;
        if (bus.entry_count !== CNT_W'(exp_en_cnt) || bus.exit_count !== CNT_W'(exp_ex_cnt)
            || bus.denied_count !== CNT_W'(exp_dn_cnt)) begin
            bad++;
            $display("FAIL %s counts: got en=%0d ex=%0d dn=%0d, expected en=%0d ex=%0d dn=%0d",
                     tag, bus.entry_count, bus.exit_count, bus.denied_count,
                     exp_en_cnt, exp_ex_cnt, exp_dn_cnt);
        end
    endtask

    // One transaction window on either or both lanes. pass = cycle of OPEN
    // (1-based) on which the loop sensor fires; 0 or > GATE_TIMEOUT = never.
    // Called and returns on a negedge with both lanes idle.
    task automatic run_txn(input string tag,
                           input logic en, input logic en_uni, input int en_pass,
                           input logic ex, input logic ex_uni, input int ex_pass,
                           input logic uni_sp, input logic free_sp);
        logic en_space, en_car, ex_car;
        int   exp_en_open, exp_ex_open, en_open, ex_open, en_pulse_c, ex_pulse_c;

        en_space = en_uni ? uni_sp : free_sp;
        en_car   = en && en_space && en_pass >= 1 && en_pass <= GATE_TIMEOUT;
        ex_car   = ex && ex_pass >= 1 && ex_pass <= GATE_TIMEOUT;

        if (en) begin
            if (!en_space) begin
                en_q.push_back(EV_DENIED);
                if (exp_dn_cnt < SAT) exp_dn_cnt++;
            end else if (en_car) begin
                en_q.push_back(en_uni ? EV_CAR_UNI : EV_CAR_FREE);
                if (exp_en_cnt < SAT) exp_en_cnt++;
                exp_en_uni = en_uni;
            end else begin
                en_q.push_back(EV_TIMEOUT);
            end
        end
        if (ex) begin
            if (ex_car) begin
                ex_q.push_back(ex_uni ? EV_CAR_UNI : EV_CAR_FREE);
                if (exp_ex_cnt < SAT) exp_ex_cnt++;
                exp_ex_uni = ex_uni;
            end else begin
                ex_q.push_back(EV_TIMEOUT);
            end
        end
        exp_en_open = (en && en_space) ? (en_car ? en_pass : GATE_TIMEOUT) : 0;
        exp_ex_open = ex ? (ex_car ? ex_pass : GATE_TIMEOUT) : 0;

        bus.entry_request         = en;
        bus.entry_is_uni          = en_uni;
        bus.exit_request          = ex;
        bus.exit_is_uni           = ex_uni;
        bus.uni_is_vacated_space  = uni_sp;
        bus.free_is_vacated_space = free_sp;
        @(negedge clock);

        en_open = 0; ex_open = 0; en_pulse_c = -1; ex_pulse_c = -1;
        for (int c = 1; c <= GATE_TIMEOUT + 3; c++) begin
            if (bus.entry_gate_open === 1'b1) en_open++;
            if (bus.exit_gate_open === 1'b1)  ex_open++;
            if (bus.car_entered === 1'b1)     en_pulse_c = c;
            if (bus.car_exited === 1'b1)      ex_pulse_c = c;
            // Requests drop and space vanishes; an open gate must not abort.
            bus.entry_request         = 1'b0;
            bus.exit_request          = 1'b0;
            bus.uni_is_vacated_space  = 1'b0;
            bus.free_is_vacated_space = 1'b0;
            bus.entry_passed          = en && (c == en_pass);
            bus.exit_passed           = ex && (c == ex_pass);
            @(negedge clock);
        end
        bus.entry_passed = 1'b0;
        bus.exit_passed  = 1'b0;

        total++;
        if (en_open != exp_en_open || ex_open != exp_ex_open) begin
            bad++;
            $display("FAIL %s gate_open_cycles: got en=%0d ex=%0d, expected en=%0d ex=%0d",
                     tag, en_open, ex_open, exp_en_open, exp_ex_open);
        end
        if (en_car) begin
            total++;
            if (en_pulse_c != en_pass + 1) begin
                bad++;
                $display("FAIL %s car_entered_cycle: got %0d, expected %0d",
                         tag, en_pulse_c, en_pass + 1);
            end
        end
        if (ex_car) begin
            total++;
            if (ex_pulse_c != ex_pass + 1) begin
                bad++;
                $display("FAIL %s car_exited_cycle: got %0d, expected %0d",
                         tag, ex_pulse_c, ex_pass + 1);
            end
        end
        total++;
        if (bus.is_uni_car_entered !== exp_en_uni || bus.is_uni_car_exited !== exp_ex_uni) begin
            bad++;
            $display("FAIL %s held_class: got en=%b ex=%b, expected en=%b ex=%b",
                     tag, bus.is_uni_car_entered, bus.is_uni_car_exited, exp_en_uni, exp_ex_uni);
        end
        total++;
        if (en_q.size() != 0 || ex_q.size() != 0) begin
            bad++;
            $display("FAIL %s missing_events: got en_left=%0d ex_left=%0d, expected 0",
                     tag, en_q.size(), ex_q.size());
            en_q.delete();
            ex_q.delete();
        end
        check_counts(tag);
    endtask

    // ------------------------------------------------------------ scenarios
    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        total++;
        if ({bus.car_entered, bus.is_uni_car_entered, bus.car_exited, bus.is_uni_car_exited,
             bus.entry_gate_open, bus.exit_gate_open, bus.entry_denied, bus.gate_timeout}
            !== 9'b0) begin
            bad++;
            $display("FAIL reset_outputs: got ce=%b ue=%b cx=%b ux=%b eg=%b xg=%b dn=%b to=%b, expected all 0",
                     bus.car_entered, bus.is_uni_car_entered, bus.car_exited,
                     bus.is_uni_car_exited, bus.entry_gate_open, bus.exit_gate_open,
                     bus.entry_denied, bus.gate_timeout);
        end
        check_counts("reset");
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_uni_entry();
        run_txn("uni_entry", 1'b1, 1'b1, 3, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_denied();
        // Uni space exists but a free car needs a free space.
        run_txn("denied", 1'b1, 1'b0, 3, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_exit_timeout();
        run_txn("exit_timeout", 1'b0, 1'b0, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_entry_timeout();
        run_txn("entry_timeout", 1'b1, 1'b0, 0, 1'b1, 1'b1, 1, 1'b0, 1'b1);
    endtask

    task automatic test_simultaneous();
        run_txn("simultaneous", 1'b1, 1'b1, 2, 1'b1, 1'b0, 2, 1'b1, 1'b1);
    endtask

    task automatic test_pass_on_last_cycle();
        run_txn("pass_last", 1'b1, 1'b0, GATE_TIMEOUT, 1'b1, 1'b1, GATE_TIMEOUT, 1'b0, 1'b1);
    endtask

    // Request held high with no space: each IDLE cycle is a fresh refusal,
    // long enough to drive denied_count into saturation.
    task automatic test_back_to_back_denied();
        bus.entry_request         = 1'b1;
        bus.entry_is_uni          = 1'b1;
        bus.uni_is_vacated_space  = 1'b0;
        bus.free_is_vacated_space = 1'b1;
        for (int i = 0; i < SAT + 5; i++) begin
            en_q.push_back(EV_DENIED);
            if (exp_dn_cnt < SAT) exp_dn_cnt++;
            @(negedge clock);
        end
        drive_idle();
        @(negedge clock);
        total++;
        if (en_q.size() != 0 || bus.entry_gate_open !== 1'b0) begin
            bad++;
            $display("FAIL denied_flood: got left=%0d gate=%b, expected left=0 gate=0",
                     en_q.size(), bus.entry_gate_open);
            en_q.delete();
        end
        check_counts("denied_flood");
    endtask

    task automatic test_saturation();
        while (exp_en_cnt < SAT)
            run_txn("fill", 1'b1, 1'b0, 1, 1'b1, 1'b0, 1, 1'b0, 1'b1);
        run_txn("saturated", 1'b1, 1'b1, 1, 1'b1, 1'b1, 1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_open();
        bus.entry_request        = 1'b1;
        bus.entry_is_uni         = 1'b1;
        bus.uni_is_vacated_space = 1'b1;
        @(negedge clock);
        drive_idle();
        @(negedge clock);
        total++;
        if (bus.entry_gate_open !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_open_pre: got gate=%b, expected 1", bus.entry_gate_open);
        end
        // Reset and passed together: reset must win, no car reported.
        reset            = 1'b1;
        bus.entry_passed = 1'b1;
        @(negedge clock);
        reset            = 1'b0;
        bus.entry_passed = 1'b0;
        exp_en_cnt = 0; exp_ex_cnt = 0; exp_dn_cnt = 0;
        exp_en_uni = 1'b0; exp_ex_uni = 1'b0;
        total++;
        if (bus.entry_gate_open !== 1'b0 || bus.car_entered !== 1'b0
            || bus.is_uni_car_entered !== 1'b0 || bus.is_uni_car_exited !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_open: got gate=%b car=%b ue=%b ux=%b, expected all 0",
                     bus.entry_gate_open, bus.car_entered, bus.is_uni_car_entered,
                     bus.is_uni_car_exited);
        end
        check_counts("reset_mid_open");
        repeat (GATE_TIMEOUT + 2) @(negedge clock);
        check_counts("after_reset");
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_uni_entry();
        test_denied();
        test_exit_timeout();
        test_entry_timeout();
        test_simultaneous();
        test_pass_on_last_cycle();
        test_back_to_back_denied();
        test_saturation();
        test_reset_mid_open();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parking_gate_controller.md
PARKING_GATE_CONTROLLER -- requirements
Module: parking_gate_controller

Interface
REQ-001 Parameter GATE_TIMEOUT, default 16, is the max clock cycles a barrier stays open waiting for the car-passed sensor (legal range 2..255).
REQ-002 Parameter CNT_W, default 10, is the width of the statistics counters.
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the clock rising edge.
REQ-005 entry_request  input  1  car present at entry barrier.
REQ-006 entry_is_uni  input  1  entry car class; 1 = university, 0 = free; valid with entry_request.
REQ-007 entry_passed  input  1  entry loop sensor; car has crossed the barrier.
REQ-008 exit_request  input  1  car present at exit barrier.
REQ-009 exit_is_uni  input  1  exit car class; valid with exit_request.
REQ-010 exit_passed  input  1  exit loop sensor.
REQ-011 uni_is_vacated_space  input  1  from the occupancy counter; uni space available.
REQ-012 free_is_vacated_space  input  1  from the occupancy counter; free space available.
REQ-013 car_entered  output  1  one-cycle pulse per completed entry; the counter counts on its falling edge.
REQ-014 is_uni_car_entered  output  1  class of the reported entry.
REQ-015 car_exited  output  1  one-cycle pulse per completed exit.
REQ-016 is_uni_car_exited  output  1  class of the reported exit.
REQ-017 entry_gate_open  output  1  entry barrier drive.
REQ-018 exit_gate_open  output  1  exit barrier drive.
REQ-019 entry_denied  output  1  one-cycle pulse when entry is refused for lack of space.
REQ-020 gate_timeout  output  2  one-cycle pulses; bit0 = entry timeout, bit1 = exit timeout.
REQ-021 entry_count, exit_count, denied_count  output  CNT_W each  saturating statistics counters.

Function
REQ-022 Entry and exit each use an independent FSM with states IDLE, OPEN, REPORT, HOLD; both SHALL be able to act in the same cycle.
REQ-023 IDLE: with entry_request=1, latch entry_is_uni; if the matching space flag (uni_is_vacated_space or free_is_vacated_space) =1, go to OPEN next cycle; else pulse entry_denied for 1 cycle, increment denied_count, stay IDLE.
REQ-024 Exit IDLE: exit_request=1 latches exit_is_uni and always goes to OPEN; no space check.
REQ-025 OPEN: gate_open=1; a wait counter starts at 0 on entry to OPEN and increments each cycle.
REQ-026 OPEN with passed=1 -> REPORT next cycle; gate_open falls on that transition.
REQ-027 OPEN with passed=0 and wait counter = GATE_TIMEOUT-1 -> IDLE; pulse the gate_timeout bit for 1 cycle; no car pulse, no count change.
REQ-028 Timeout when passed=1 on the same cycle: passed wins (REPORT).
REQ-029 REPORT: car_entered/car_exited=1 for exactly 1 cycle; is_uni_* equals the latched class; increment entry_count/exit_count; -> HOLD.
REQ-030 HOLD: car pulse=0, is_uni_* held at the latched value for 1 cycle so the class is stable at the falling edge; -> IDLE.
REQ-031 is_uni_* outputs SHALL change only on entry to REPORT; otherwise they hold their last value.
REQ-032 Requests and passed inputs outside the states that sample them SHALL be ignored; a request still high on return to IDLE starts a new transaction.
REQ-033 Space flags are sampled only in IDLE on request; later changes do not abort an open gate.
REQ-034 Statistics counters saturate at 2^CNT_W-1 and do not wrap.
REQ-035 Latency: request (space available) -> gate_open = 1 cycle; passed -> car pulse = 1 cycle; minimum transaction = 4 cycles.

Reset
REQ-036 When reset=1 at a rising edge, both FSMs go to IDLE; all outputs, latches, wait counters and statistics counters go to 0 on that edge, including mid-OPEN or mid-REPORT, with no car pulse emitted.
REQ-037 Reset overrides all other inputs in the same cycle.

Verification
REQ-038 entry_request=1, entry_is_uni=1, uni flag=1, entry_passed at 3rd OPEN cycle -> gate open 3 cycles, car_entered 1-cycle pulse with is_uni_car_entered=1, entry_count=1.
REQ-039 entry_request=1, entry_is_uni=0, free flag=0 -> entry_denied 1-cycle pulse, gate never opens, denied_count=1.
REQ-040 exit_request=1, exit_passed never asserted -> exit_gate_open for 16 cycles, gate_timeout=2'b10 for 1 cycle, no car_exited, exit_count=0.
REQ-041 entry and exit requests same cycle, both passed same cycle -> car_entered and car_exited pulse in the same cycle, both counts increment.
REQ-042 reset asserted during entry OPEN -> gate closes next edge, no car_entered, all counters 0.
REQ-043 entry_count preset to 1023 via 1023 transactions, one more entry -> entry_count stays 1023, car_entered still pulses.
